// File: rtl/irq_pkg.sv
// Shared constants and FSM state encoding for the 16-line interrupt controller.
package irq_pkg;
  localparam int NUM_IRQ = 16;
  localparam int VEC_W   = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    VALID  = 2'b01,
    ACTIVE = 2'b10
  } state_t;
endpackage

// File: rtl/prio_enc16.sv
// 16-to-4 priority encoder; the highest set bit wins and any flags a non-empty input.
module prio_enc16
  import irq_pkg::*;
(
  input  logic [NUM_IRQ-1:0] req,
  output logic [VEC_W-1:0]   idx,
  output logic               any
);
  // Ascending scan, so later (higher) indices overwrite lower ones.
  always_comb begin
    idx = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      if (req[i]) idx = VEC_W'(i);
  end

  assign any = |req;
endmodule

// File: rtl/irq_prio_ctrl16.sv
// Edge-captured, maskable 16-line interrupt controller with valid/ack/EOI handshake.
// Define IRQ_SYNC_EN to add a 2-flop synchroniser on every request line.
module irq_prio_ctrl16 #(
  parameter int          NUM_IRQ    = 16,
  parameter int          VEC_W      = 4,
  parameter logic [15:0] RESET_MASK = 16'hFFFF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_IRQ-1:0] irq_req,
  input  logic               mask_we,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic               irq_ack,
  input  logic               eoi,
  output logic               irq_valid,
  output logic [VEC_W-1:0]   irq_vec,
  output logic               irq_active,
  output logic [NUM_IRQ-1:0] pending,
  output logic [NUM_IRQ-1:0] mask
);
  import irq_pkg::*;

  state_t             state, state_nxt;
  logic [NUM_IRQ-1:0] req_in, req_d, req_q, rise, eligible, clr;
  logic [VEC_W-1:0]   win_idx;
  logic               win_any, grant, accept;

`ifdef IRQ_SYNC_EN
  logic [NUM_IRQ-1:0] sync1, sync2;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= irq_req;
      sync2 <= sync1;
    end
  end
  assign req_in = sync2;
`else
  assign req_in = irq_req;
`endif

  // req_d is the sampled request, req_q its previous value: rise = 0->1 transition.
  assign rise     = req_d & ~req_q;
  assign eligible = pending & ~mask;
  assign accept   = (state == VALID) && irq_ack;
  assign grant    = (state == IDLE) && en && win_any;

  always_comb begin
    clr = '0;
    if (accept) clr[irq_vec] = 1'b1;
  end

  prio_enc16 u_enc (
    .req (eligible),
    .idx (win_idx),
    .any (win_any)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_d   <= '0;
      req_q   <= '0;
      pending <= '0;
      mask    <= RESET_MASK;
      irq_vec <= '0;
    end else begin
      req_d   <= req_in;
      req_q   <= req_d;
      // A fresh edge on the line being acked wins over the clear.
      pending <= (pending & ~clr) | rise;
      if (mask_we) mask <= mask_wdata;
      if (grant) irq_vec <= win_idx;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant)   state_nxt = VALID;
      VALID:   if (irq_ack) state_nxt = ACTIVE;
      ACTIVE:  if (eoi)     state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  assign irq_valid  = (state == VALID);
  assign irq_active = (state == ACTIVE);
endmodule

// File: tb/tb_irq_prio_ctrl16.sv
// Directed table-driven bench for irq_prio_ctrl16 plus hand-written reset and latency sequences.
module tb_irq_prio_ctrl16;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en = 1'b0;
  logic [15:0] irq_req = '0;
  logic        mask_we = 1'b0;
  logic [15:0] mask_wdata = '0;
  logic        irq_ack = 1'b0;
  logic        eoi = 1'b0;
  logic        irq_valid;
  logic [3:0]  irq_vec;
  logic        irq_active;
  logic [15:0] pending;
  logic [15:0] mask;

  int n_vec = 0;
  int n_err = 0;

`ifdef IRQ_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  always #5 clk = ~clk;

  irq_prio_ctrl16 dut (
    .clk(clk), .rst_n(rst_n), .en(en), .irq_req(irq_req),
    .mask_we(mask_we), .mask_wdata(mask_wdata), .irq_ack(irq_ack), .eoi(eoi),
    .irq_valid(irq_valid), .irq_vec(irq_vec), .irq_active(irq_active),
    .pending(pending), .mask(mask)
  );

  typedef struct {
    logic        en;
    logic [15:0] req;
    logic        mwe;
    logic [15:0] mwd;
    logic        ack;
    logic        eoi;
    logic        v;
    logic [3:0]  vec;
    logic        a;
    logic [15:0] pend;
    logic [15:0] msk;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(logic e, logic [15:0] r, logic mw, logic [15:0] md,
                              logic ak, logic eo, logic v, logic [3:0] vc,
                              logic a, logic [15:0] p, logic [15:0] m);
    row_t t;
    t.en = e; t.req = r; t.mwe = mw; t.mwd = md; t.ack = ak; t.eoi = eo;
    t.v = v; t.vec = vc; t.a = a; t.pend = p; t.msk = m;
    return t;
  endfunction

  task automatic check(string name, logic v, logic [3:0] vc, logic a,
                       logic [15:0] p, logic [15:0] m);
    n_vec++;
    if ({irq_valid, irq_vec, irq_active, pending, mask} !== {v, vc, a, p, m}) begin
      n_err++;
      $display("FAIL %s: got valid=%0b vec=%0d active=%0b pending=%h mask=%h, want valid=%0b vec=%0d active=%0b pending=%h mask=%h",
               name, irq_valid, irq_vec, irq_active, pending, mask, v, vc, a, p, m);
    end
  endtask

  task automatic drive(logic e, logic [15:0] r, logic mw, logic [15:0] md, logic ak, logic eo);
    @(negedge clk);
    en = e; irq_req = r; mask_we = mw; mask_wdata = md; irq_ack = ak; eoi = eo;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0; irq_req = '0; mask_we = 1'b0; mask_wdata = '0; irq_ack = 1'b0; eoi = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Test 1: single edge on line 5, two-cycle latency, clear on ack.
    tbl.push_back(mk(1, 16'h0000, 1, 16'h0000, 0, 0, 0, 0,  0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 16'h0020, 0, 16'h0000, 0, 0, 0, 0,  0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 0, 0,  0, 16'h0020, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 5,  0, 16'h0020, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 5,  0, 16'h0020, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 5,  1, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 5,  0, 16'h0000, 16'h0000));
    // Test 2: lines 3 and 12 together, held high for two cycles (no re-trigger).
    tbl.push_back(mk(1, 16'h1008, 0, 16'h0000, 0, 0, 0, 5,  0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 16'h1008, 0, 16'h0000, 0, 0, 0, 5,  0, 16'h1008, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 12, 0, 16'h1008, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 12, 1, 16'h0008, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 0, 12, 1, 16'h0008, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 12, 0, 16'h0008, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 3,  0, 16'h0008, 16'h0000));
    // Test 3: higher request arrives while vector 3 is presented.
    tbl.push_back(mk(1, 16'h4000, 0, 16'h0000, 0, 0, 1, 3,  0, 16'h0008, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 3,  0, 16'h4008, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 3,  1, 16'h4000, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 3,  0, 16'h4000, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 14, 0, 16'h4000, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 14, 1, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 14, 0, 16'h0000, 16'h0000));
    // Test 4: masked line accumulates pending, granted after unmasking.
    tbl.push_back(mk(1, 16'h0000, 1, 16'h0100, 0, 0, 0, 14, 0, 16'h0000, 16'h0100));
    tbl.push_back(mk(1, 16'h0100, 0, 16'h0000, 0, 0, 0, 14, 0, 16'h0000, 16'h0100));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 0, 14, 0, 16'h0100, 16'h0100));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 0, 14, 0, 16'h0100, 16'h0100));
    tbl.push_back(mk(1, 16'h0000, 1, 16'h0000, 0, 0, 0, 14, 0, 16'h0100, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 8,  0, 16'h0100, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 8,  1, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 8,  0, 16'h0000, 16'h0000));
    // New edge on the acked line in the ack cycle: set wins; stray ack in ACTIVE ignored.
    tbl.push_back(mk(1, 16'h0080, 0, 16'h0000, 0, 0, 0, 8,  0, 16'h0000, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 0, 8,  0, 16'h0080, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 7,  0, 16'h0080, 16'h0000));
    tbl.push_back(mk(1, 16'h0080, 0, 16'h0000, 0, 0, 1, 7,  0, 16'h0080, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 7,  1, 16'h0080, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 7,  1, 16'h0080, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 1, 0, 7,  0, 16'h0080, 16'h0000));
    // Test 6: en=0 blocks the grant, en=1 grants on the next edge.
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 7,  0, 16'h0080, 16'h0000));
    tbl.push_back(mk(0, 16'h0000, 0, 16'h0000, 0, 0, 0, 7,  0, 16'h0080, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 0, 0, 1, 7,  0, 16'h0080, 16'h0000));
    tbl.push_back(mk(1, 16'h0000, 0, 16'h0000, 1, 0, 0, 7,  1, 16'h0000, 16'h0000));

    // Reset state while rst_n is held low.
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 0, 0, 0, 16'h0000, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;

`ifndef IRQ_SYNC_EN
    foreach (tbl[i]) begin
      drive(tbl[i].en, tbl[i].req, tbl[i].mwe, tbl[i].mwd, tbl[i].ack, tbl[i].eoi);
      check($sformatf("row%0d", i), tbl[i].v, tbl[i].vec, tbl[i].a, tbl[i].pend, tbl[i].msk);
    end

    // Test 5: asynchronous reset while ACTIVE, then a stray eoi.
    if (!irq_active) begin
      n_vec++; n_err++;
      $display("FAIL pre_reset_active: got active=%0b, want 1", irq_active);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", 0, 0, 0, 16'h0000, 16'hFFFF);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 16'h0000, 0, 16'h0000, 0, 1);
    check("stray_eoi", 0, 0, 0, 16'h0000, 16'hFFFF);
    drive(1, 16'h0000, 0, 16'h0000, 0, 0);
    check("after_stray_eoi", 0, 0, 0, 16'h0000, 16'hFFFF);
`endif

    // Request-to-valid latency measured from the sampling edge.
    do_reset();
    drive(1, 16'h0000, 1, 16'h0000, 0, 0);
    drive(1, 16'h0020, 0, 16'h0000, 0, 0);
    begin
      int n;
      n = 0;
      while (!irq_valid && n < 10) begin
        drive(1, 16'h0000, 0, 16'h0000, 0, 0);
        n++;
      end
      n_vec++;
      if (n != LAT || irq_vec != 4'd5) begin
        n_err++;
        $display("FAIL latency: got %0d cycles vec=%0d valid=%0b, want %0d cycles vec=5",
                 n, irq_vec, irq_valid, LAT);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/irq_prio_ctrl16.md
Name: irq_prio_ctrl16

Overview:
- 16-line interrupt request controller that feeds the CPU's 16-to-4 vector encoding stage.
- Captures rising edges on 16 request lines into a pending register and applies a software-writable mask.
- Selects the highest-priority unmasked pending request and presents its 4-bit vector to the core.
- Valid/ack handshake to the core, then an active phase that ends on end-of-interrupt (EOI).

Parameters:
- NUM_IRQ, 16, number of request lines; fixed at 16, other values unsupported.
- VEC_W, 4, vector width; must equal log2(NUM_IRQ).
- RESET_MASK, 16'hFFFF, mask value loaded at reset; 1 = line blocked.

Ports:
- clk  input  1  system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- en  input  1  global enable; 0 blocks new grants.
- irq_req  input  16  raw request lines; bit 15 has highest priority.
- mask_we  input  1  mask write strobe.
- mask_wdata  input  16  new mask value.
- irq_ack  input  1  core accepts the presented vector.
- eoi  input  1  core finished the service routine (one-cycle pulse).
- irq_valid  output  1  vector is presented and awaiting ack.
- irq_vec  output  4  index of the granted request.
- irq_active  output  1  service routine in progress.
- pending  output  16  current pending register.
- mask  output  16  current mask register.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - irq_valid=0, irq_vec=0, irq_active=0, pending=0, mask=RESET_MASK.
  - State IDLE; edge-detect history register = 0.
- Reset mid-operation (any state) aborts immediately; no ack or EOI is required afterwards.
- Edge capture:
  - req_d <= irq_req (or the synchronised version, see Optional Feature).
  - pending[i] sets when req_d[i]=1 and its previous registered value was 0.
  - Level-high lines do not re-trigger until they return to 0.
- Clear on ack: pending[irq_vec] clears on the cycle irq_ack is accepted. If a new edge on that same line arrives in the same cycle, set wins and the bit stays 1.
- Mask:
  - mask_we=1 loads mask_wdata on the next edge.
  - Masked lines still accumulate pending; they are only excluded from selection.
- Selection: eligible = pending & ~mask; the highest set index wins.
- FSM, IDLE:
  - irq_valid=0, irq_active=0.
  - If en=1 and eligible!=0: latch irq_vec = winning index, go to VALID.
- FSM, VALID:
  - irq_valid=1; irq_vec held stable, even if a higher request, a mask change or en=0 occurs.
  - On irq_ack=1: clear the pending bit, go to ACTIVE with irq_valid=0 in the next cycle.
- FSM, ACTIVE:
  - irq_active=1; no new grant is made.
  - On eoi=1: go to IDLE. A new grant can appear at the earliest 1 cycle after returning to IDLE.
- Ignored inputs: irq_ack outside VALID and eoi outside ACTIVE have no effect.
- Latency without sync:
  - Edge on irq_req sampled at edge t.
  - Pending set at t+1.
  - irq_valid=1 at t+2 (from IDLE, en=1, unmasked).
- Simultaneous edges on several lines all become pending; they are served in descending index order across successive grants.

Optional Feature:
- Macro: IRQ_SYNC_EN.
- Defined: each irq_req bit passes through a 2-flop synchroniser (reset to 0) before edge detection; request-to-valid latency becomes 4 cycles.
- Undefined: irq_req is taken as synchronous to clk and registered once; latency is 2 cycles.

Decomposition:
- Package irq_pkg:
  - NUM_IRQ and VEC_W constants.
  - FSM state typedef: IDLE=2'b00, VALID=2'b01, ACTIVE=2'b10.
- Sub-module prio_enc16:
  - Combinational, 16-bit input, 4-bit index output plus any flag.
  - Highest set bit wins; instantiated once on the eligible vector.

Test Plan:
1. Reset, then mask_we with mask_wdata=16'h0000, en=1; pulse irq_req[5] -> irq_valid=1, irq_vec=4'd5 two cycles after the edge; pending=16'h0020 until ack.
2. irq_req bits 3 and 12 rise in the same cycle -> irq_vec=12 first; after ack and eoi, irq_vec=3; pending=16'h0000 at end.
3. In VALID with irq_vec=3, raise irq_req[14] -> irq_vec stays 3 until ack; 14 is granted after eoi.
4. mask=16'h0100 and irq_req[8] pulses -> pending[8]=1 and irq_valid stays 0; write mask=16'h0000 -> irq_vec=8 granted.
5. In ACTIVE, assert rst_n=0 -> all outputs 0 and mask=16'hFFFF asynchronously; a stray eoi after reset release has no effect.
6. en=0 with pending[2]=1 -> no grant; en=1 -> irq_valid next cycle. With IRQ_SYNC_EN defined, repeat test 1 -> valid 4 cycles after the edge.
